// File: rtl/pll_lock_monitor_if.sv
// Status/control bundle between the PLL lock monitor (slave) and whoever drives/observes it (master).
// The heartbeat signal exists only when LOCK_MON_HEARTBEAT_EN is defined.
interface pll_lock_monitor_if #(
  parameter int CNT_WIDTH = 8
);
  logic                 locked_in;
  logic                 clear_errors;
  logic                 sys_reset_out;
  logic                 ready;
  logic [CNT_WIDTH-1:0] loss_count;
  logic                 loss_sticky;
`ifdef LOCK_MON_HEARTBEAT_EN
  logic                 heartbeat;

  modport master (
    output locked_in,
    output clear_errors,
    input  sys_reset_out,
    input  ready,
    input  loss_count,
    input  loss_sticky,
    input  heartbeat
  );

  modport slave (
    input  locked_in,
    input  clear_errors,
    output sys_reset_out,
    output ready,
    output loss_count,
    output loss_sticky,
    output heartbeat
  );
`else
  modport master (
    output locked_in,
    output clear_errors,
    input  sys_reset_out,
    input  ready,
    input  loss_count,
    input  loss_sticky
  );

  modport slave (
    input  locked_in,
    input  clear_errors,
    output sys_reset_out,
    output ready,
    output loss_count,
    output loss_sticky
  );
`endif
endinterface

// File: rtl/pll_lock_monitor.sv
// PLL lock qualifier and downstream system-reset generator with loss-of-lock statistics.
// Optional heartbeat output enabled by defining LOCK_MON_HEARTBEAT_EN.
module pll_lock_monitor #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 1024,
  parameter int HOLD_CYCLES   = 16,
  parameter int CNT_WIDTH     = 8,
  parameter int HB_BITS       = 24
) (
  input logic               clock,
  input logic               reset,
  pll_lock_monitor_if.slave bus
);

  localparam int MAX_CYCLES = (STABLE_CYCLES > HOLD_CYCLES) ? STABLE_CYCLES : HOLD_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD_CYCLES - 1);

  localparam logic [1:0] ST_WAIT_LOCK = 2'd0;
  localparam logic [1:0] ST_STABILIZE = 2'd1;
  localparam logic [1:0] ST_HOLD      = 2'd2;
  localparam logic [1:0] ST_RUN       = 2'd3;

  if (SYNC_STAGES < 2 || STABLE_CYCLES < 1 || HOLD_CYCLES < 1 || CNT_WIDTH < 1 || HB_BITS < 1)
  begin : g_bad_params
    $error("pll_lock_monitor: illegal parameter value");
  end

  // ---------------------------------------------------------------------------
  // Lock synchroniser
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   lock_s;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], bus.locked_in};
    end
  end

  assign lock_s = sync_reg[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // Qualification FSM
  // ---------------------------------------------------------------------------
  logic [1:0]    state_reg;
  logic [1:0]    state_next;
  logic [CW-1:0] cnt_reg;
  logic [CW-1:0] cnt_next;
  logic          loss_event;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    loss_event = 1'b0;
    case (state_reg)
      ST_WAIT_LOCK: begin
        if (lock_s) begin
          state_next = ST_STABILIZE;
          cnt_next   = '0;
        end
      end
      ST_STABILIZE: begin
        if (!lock_s) begin
          state_next = ST_WAIT_LOCK;
          cnt_next   = '0;
        end else if (cnt_reg == STABLE_LAST) begin
          state_next = ST_HOLD;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      ST_HOLD: begin
        if (!lock_s) begin
          state_next = ST_WAIT_LOCK;
          cnt_next   = '0;
        end else if (cnt_reg == HOLD_LAST) begin
          state_next = ST_RUN;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      ST_RUN: begin
        if (!lock_s) begin
          state_next = ST_WAIT_LOCK;
          cnt_next   = '0;
          loss_event = 1'b1;
        end
      end
      default: begin
        state_next = ST_WAIT_LOCK;
        cnt_next   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Loss-of-lock statistics; a loss coinciding with clear_errors still counts once
  // ---------------------------------------------------------------------------
  logic [CNT_WIDTH-1:0] loss_count_reg;
  logic [CNT_WIDTH-1:0] loss_count_next;
  logic                 loss_sticky_reg;
  logic                 loss_sticky_next;

  always_comb begin
    loss_count_next  = loss_count_reg;
    loss_sticky_next = loss_sticky_reg;
    if (loss_event) begin
      loss_sticky_next = 1'b1;
      if (bus.clear_errors) begin
        loss_count_next = CNT_WIDTH'(1);
      end else if (!(&loss_count_reg)) begin
        loss_count_next = loss_count_reg + 1'b1;
      end
    end else if (bus.clear_errors) begin
      loss_count_next  = '0;
      loss_sticky_next = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // State and output registers; outputs are decoded from state_next so they
  // change on the same edge as the state register
  // ---------------------------------------------------------------------------
  logic sys_reset_reg;
  logic ready_reg;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg       <= ST_WAIT_LOCK;
      cnt_reg         <= '0;
      sys_reset_reg   <= 1'b1;
      ready_reg       <= 1'b0;
      loss_count_reg  <= '0;
      loss_sticky_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      cnt_reg         <= cnt_next;
      sys_reset_reg   <= (state_next != ST_RUN);
      ready_reg       <= (state_next == ST_RUN);
      loss_count_reg  <= loss_count_next;
      loss_sticky_reg <= loss_sticky_next;
    end
  end

  assign bus.sys_reset_out = sys_reset_reg;
  assign bus.ready         = ready_reg;
  assign bus.loss_count    = loss_count_reg;
  assign bus.loss_sticky   = loss_sticky_reg;

`ifdef LOCK_MON_HEARTBEAT_EN
  // Divider runs only while the next state is RUN, so the blink stops with ready.
  logic [HB_BITS-1:0] hb_cnt_reg;
  logic               hb_reg;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hb_cnt_reg <= '0;
      hb_reg     <= 1'b0;
    end else if (state_next != ST_RUN) begin
      hb_cnt_reg <= '0;
      hb_reg     <= 1'b0;
    end else begin
      hb_cnt_reg <= hb_cnt_reg + 1'b1;
      if (&hb_cnt_reg) begin
        hb_reg <= ~hb_reg;
      end
    end
  end

  assign bus.heartbeat = hb_reg;
`endif

endmodule

// File: tb/tb_pll_lock_monitor.sv
// Randomised and directed bench for pll_lock_monitor against a run-length reference model.
// Heartbeat is also checked when LOCK_MON_HEARTBEAT_EN is defined.
module tb_pll_lock_monitor;

  localparam int SYNC   = 2;
  localparam int STABLE = 8;
  localparam int HOLD   = 4;
  localparam int CW     = 2;
  localparam int HB     = 3;
  localparam int QUAL   = STABLE + HOLD + 1;    // consecutive synced-high edges needed for RUN
  localparam int LAT    = SYNC + 1 + STABLE + HOLD;
  localparam int CMAX   = (1 << CW) - 1;

  logic clock = 1'b0;
  logic reset = 1'b1;

  pll_lock_monitor_if #(.CNT_WIDTH(CW)) bus ();

  pll_lock_monitor #(
    .SYNC_STAGES  (SYNC),
    .STABLE_CYCLES(STABLE),
    .HOLD_CYCLES  (HOLD),
    .CNT_WIDTH    (CW),
    .HB_BITS      (HB)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference model: lock_s is locked_in delayed SYNC edges; RUN means the
  // synced lock has been high for QUAL consecutive edges.
  logic [SYNC-1:0] m_sync;
  int              m_run;
  int              m_run_edges;
  logic            m_ready;
  int              m_count;
  logic            m_sticky;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_sync      = '0;
    m_run       = 0;
    m_run_edges = 0;
    m_ready     = 1'b0;
    m_count     = 0;
    m_sticky    = 1'b0;
  endtask

  task automatic model_edge(input logic lk, input logic clr);
    logic ls;
    logic loss;
    ls     = m_sync[SYNC-1];
    m_sync = {m_sync[SYNC-2:0], lk};
    m_run  = ls ? ((m_run < 1000) ? m_run + 1 : m_run) : 0;
    loss   = m_ready && !ls;
    if (loss) begin
      m_sticky = 1'b1;
      m_count  = clr ? 1 : ((m_count < CMAX) ? m_count + 1 : CMAX);
    end else if (clr) begin
      m_count  = 0;
      m_sticky = 1'b0;
    end
    m_ready     = (m_run >= QUAL);
    m_run_edges = m_ready ? m_run_edges + 1 : 0;
  endtask

  task automatic compare();
    check("sys_reset_out", 32'(bus.sys_reset_out), 32'(!m_ready));
    check("ready",         32'(bus.ready),         32'(m_ready));
    check("loss_count",    32'(bus.loss_count),    32'(m_count));
    check("loss_sticky",   32'(bus.loss_sticky),   32'(m_sticky));
`ifdef LOCK_MON_HEARTBEAT_EN
    check("heartbeat",     32'(bus.heartbeat),     32'((m_run_edges / (1 << HB)) % 2));
`endif
  endtask

  // One clock cycle: drive, let the edge happen, update the model, compare on the falling edge.
  task automatic step(input logic lk, input logic clr);
    bus.locked_in    = lk;
    bus.clear_errors = clr;
    @(posedge clock);
    model_edge(lk, clr);
    @(negedge clock);
    compare();
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 1'b0);
      n = i + 1;
      if (bus.ready === 1'b1) break;
    end
  endtask

  task automatic wait_loss(output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      step(1'b0, 1'b0);
      n = i + 1;
      if (bus.sys_reset_out === 1'b1) break;
    end
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    #1;
    model_reset();
    check("rst_sys_reset_out", 32'(bus.sys_reset_out), 32'd1);
    check("rst_ready",         32'(bus.ready),         32'd0);
    check("rst_loss_count",    32'(bus.loss_count),    32'd0);
    check("rst_loss_sticky",   32'(bus.loss_sticky),   32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    int n;
    int len;
    logic lk;
    bus.locked_in    = 1'b0;
    bus.clear_errors = 1'b0;
    model_reset();
    @(negedge clock);
    apply_reset();

    // 1: plain qualification after reset
    repeat (3) step(1'b0, 1'b0);
    wait_ready(n);
    check("s1_latency", 32'(n), 32'(LAT));
    $display("scenario 1: qualified after %0d edges", n);

    // 3: short lock pulse must not qualify nor count as a loss
    apply_reset();
    repeat (6) step(1'b1, 1'b0);
    repeat (4) step(1'b0, 1'b0);
    wait_ready(n);
    check("s3_latency", 32'(n), 32'(LAT));
    check("s3_loss_count", 32'(bus.loss_count), 32'd0);
    $display("scenario 3: glitch ignored, qualified after %0d edges", n);

    // 2: loss from RUN, then relock
    wait_loss(n);
    check("s2_loss_latency", 32'(n), 32'(SYNC + 1));
    check("s2_loss_count", 32'(bus.loss_count), 32'd1);
    check("s2_loss_sticky", 32'(bus.loss_sticky), 32'd1);
    wait_ready(n);
    check("s2_relock_latency", 32'(n), 32'(LAT));
    $display("scenario 2: loss seen, relocked after %0d edges", n);

    // 4: saturation then clear
    step(1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      wait_loss(n);
      wait_ready(n);
    end
    check("s4_loss_count_sat", 32'(bus.loss_count), 32'd3);
    check("s4_loss_sticky", 32'(bus.loss_sticky), 32'd1);
    step(1'b1, 1'b1);
    check("s4_clear_count", 32'(bus.loss_count), 32'd0);
    check("s4_clear_sticky", 32'(bus.loss_sticky), 32'd0);
    $display("scenario 4: saturated at 3 and cleared");

    // 5: clear_errors on the very edge that sees the loss
    wait_loss(n);
    wait_ready(n);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    check("s5_loss_count", 32'(bus.loss_count), 32'd1);
    check("s5_loss_sticky", 32'(bus.loss_sticky), 32'd1);
    $display("scenario 5: loss wins over clear, count=%0d", bus.loss_count);

    // 6: async reset while in HOLD, then full requalification
    repeat (SYNC + 1 + STABLE + 1) step(1'b1, 1'b0);
    #2;
    apply_reset();
    wait_ready(n);
    check("s6_requal_latency", 32'(n), 32'(LAT));
    $display("scenario 6: reset in HOLD, requalified after %0d edges", n);

    // Random lock activity
    for (int i = 0; i < 300; i++) begin
      lk  = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 30);
      for (int j = 0; j < len; j++) begin
        step(lk, ($urandom_range(0, 15) == 0) ? 1'b1 : 1'b0);
      end
    end
    $display("random phase: lock=%0d loss_count=%0d sticky=%0d",
             bus.ready, bus.loss_count, bus.loss_sticky);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
